// File: rtl/if_pc_unit_pkg.sv
// Shared pipeline definitions for the fetch PC unit, IF/ID register and hazard unit.
package if_pc_unit_pkg;

  localparam int unsigned PC_W               = 32;
  localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/if_pc_unit.sv
// Instruction-fetch program counter: prioritised redirect/halt/stall next-PC
// selection with sticky out-of-range fault and RUN/HALT control.
module if_pc_unit
  import if_pc_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Stall_IF,
  input  logic            Branch_Taken,
  input  logic [PC_W-1:0] Branch_Target,
  input  logic            Jump,
  input  logic [PC_W-1:0] Jump_Target,
  input  logic            Halt_Req,
  input  logic            Resume,
  output logic [PC_W-1:0] PC_IF,
  output logic [PC_W-1:0] PC_Plus1_IF,
  output logic            Fetch_Valid,
  output logic            Flush_IFID,
  output logic            Halted,
  output logic            Fault
);

  localparam logic [PC_W-1:0] DEPTH = PC_W'(IMEM_DEPTH);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            fault_q, fault_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  // Next-state / next-PC selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    fault_d = fault_q;

    case (state_q)
      RUN: begin
        if (Branch_Taken || Jump) begin
          pc_d = Branch_Taken ? Branch_Target : Jump_Target;
          if (pc_d >= DEPTH) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            flush_d = 1'b1;
          end
        end else if (Halt_Req) begin
          state_d = HALT;
        end else if (!Stall_IF) begin
          pc_d = pc_inc;
          if (pc_d >= DEPTH) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        // A faulted unit only leaves HALT through reset
        if (Resume && !fault_q) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
    end
  end

  assign PC_IF       = pc_q;
  assign PC_Plus1_IF = pc_inc;
  assign Fetch_Valid = (state_q == RUN) && (pc_q < DEPTH);
  assign Flush_IFID  = flush_q;
  assign Halted      = (state_q == HALT);
  assign Fault       = fault_q;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed self-checking bench for if_pc_unit with default parameters.
module tb_if_pc_unit;

  logic        Clk;
  logic        Rst_n;
  logic        Stall_IF;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic        Halt_Req;
  logic        Resume;
  logic [31:0] PC_IF;
  logic [31:0] PC_Plus1_IF;
  logic        Fetch_Valid;
  logic        Flush_IFID;
  logic        Halted;
  logic        Fault;

  int checks   = 0;
  int failures = 0;

  if_pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(1024)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Stall_IF     (Stall_IF),
    .Branch_Taken (Branch_Taken),
    .Branch_Target(Branch_Target),
    .Jump         (Jump),
    .Jump_Target  (Jump_Target),
    .Halt_Req     (Halt_Req),
    .Resume       (Resume),
    .PC_IF        (PC_IF),
    .PC_Plus1_IF  (PC_Plus1_IF),
    .Fetch_Valid  (Fetch_Valid),
    .Flush_IFID   (Flush_IFID),
    .Halted       (Halted),
    .Fault        (Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic fv,
                         input logic fl, input logic hl, input logic ft);
    chk({tag, ".pc"}, PC_IF, pc);
    chk({tag, ".fv"}, 32'(Fetch_Valid), 32'(fv));
    chk({tag, ".flush"}, 32'(Flush_IFID), 32'(fl));
    chk({tag, ".halted"}, 32'(Halted), 32'(hl));
    chk({tag, ".fault"}, 32'(Fault), 32'(ft));
  endtask

  initial begin
    Rst_n = 1'b0; Stall_IF = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'd0;
    Jump = 1'b0; Jump_Target = 32'd0; Halt_Req = 1'b0; Resume = 1'b0;

    // Reset and free run
    step();
    Rst_n = 1'b1;
    chk_all("reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.plus1", PC_Plus1_IF, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all($sformatf("run%0d", i), 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Branch under stall at PC 5
    Stall_IF = 1'b1; Branch_Taken = 1'b1; Branch_Target = 32'd40;
    step();
    chk_all("br_stall", 32'd40, 1'b1, 1'b1, 1'b0, 1'b0);
    Branch_Taken = 1'b0;
    step();
    chk_all("stall_hold", 32'd40, 1'b1, 1'b0, 1'b0, 1'b0);
    Stall_IF = 1'b0;

    // Branch beats jump
    Branch_Taken = 1'b1; Branch_Target = 32'd8; Jump = 1'b1; Jump_Target = 32'd100;
    step();
    chk_all("br_over_jmp", 32'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    Branch_Taken = 1'b0; Jump = 1'b0;
    step();
    chk_all("after_br", 32'd9, 1'b1, 1'b0, 1'b0, 1'b0);

    // Jump alone
    Jump = 1'b1; Jump_Target = 32'd3;
    step();
    chk_all("jmp", 32'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    Jump = 1'b0;
    for (int i = 4; i <= 7; i++) step();
    chk_all("to7", 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    // Halt at 7, redirects ignored in HALT, then resume
    Halt_Req = 1'b1;
    step();
    chk_all("halt", 32'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    Halt_Req = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'd20;
    Jump = 1'b1; Jump_Target = 32'd30; Stall_IF = 1'b1;
    step();
    chk_all("halt_ign", 32'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    Branch_Taken = 1'b0; Jump = 1'b0; Stall_IF = 1'b0;
    step();
    chk_all("halt_hold", 32'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    Resume = 1'b1;
    step();
    chk_all("resume", 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    Resume = 1'b0;
    step();
    chk_all("resume_inc", 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);

    // Out-of-range jump faults, resume refused
    Jump = 1'b1; Jump_Target = 32'd1024;
    step();
    chk_all("jmp_oor", 32'd1024, 1'b0, 1'b0, 1'b1, 1'b1);
    Jump = 1'b0; Resume = 1'b1;
    step();
    chk_all("fault_resume", 32'd1024, 1'b0, 1'b0, 1'b1, 1'b1);
    Resume = 1'b0;

    // Reset in HALT with fault, overriding a branch request
    Rst_n = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'd50;
    step();
    chk_all("rst_halt", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    Rst_n = 1'b1; Branch_Taken = 1'b0;

    // Last valid word, then increment runs off the end
    Jump = 1'b1; Jump_Target = 32'd1023;
    step();
    chk_all("jmp_last", 32'd1023, 1'b1, 1'b1, 1'b0, 1'b0);
    Jump = 1'b0;
    step();
    chk_all("inc_oor", 32'd1024, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("inc_oor.plus1", PC_Plus1_IF, 32'd1025);

    // Increment wraps modulo 2^32
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFF;
    step();
    Branch_Taken = 1'b0;
    chk_all("br_max", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("wrap.plus1", PC_Plus1_IF, 32'd0);

    // Pending flush discarded by reset
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    Jump = 1'b1; Jump_Target = 32'd12;
    step();
    Jump = 1'b0; Rst_n = 1'b0;
    chk("pre_rst_flush", 32'(Flush_IFID), 32'd1);
    step();
    Rst_n = 1'b1;
    chk_all("rst_flush", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("post_rst", 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
